sha256_multiblock: RTL and testbench

Parametrised successor to the fixed two-block SHA-256 co-processor. It hashes a message of run-time-selectable length `msg_len` (32-bit words), so it is no longer hard-wired to 20 words. Padding and the length field are generated in hardware, and any number of 512-bit blocks is processed. It reads the message from and writes the eight digest words to the shared single-port word memory, and it is the building block for the bitcoin-hash top level.

---
 rtl/sha256_multiblock.sv | 208 ++++++++++++++++++++
 tb/tb_sha256_multiblock.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_multiblock.sv
// SHA-256 engine for a message of msg_len 32-bit words held in a shared single-port word memory.
// Padding and the 64-bit length field are generated here; the eight digest words are written back to memory.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | H = IV, waiting for start
//   LOAD    | 16 reads issued, 16 message/padding words captured (17 cycles)
//   COMPUTE | 64 rounds, one per cycle, over a sliding 16-word schedule
//   UPDATE  | fold working registers into H, next block or write-back
//   WRITE   | H0..H7 written to output_addr..output_addr+7
//   DONE    | one-cycle done pulse
module sha256_multiblock #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_UPDATE  = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int JW = LEN_W + 4;

    localparam logic [255:0] IV_P = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [2:0]        state;
    logic [6:0]        cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] out_addr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  nblk;
    logic [LEN_W-1:0]  blk;
    logic [JW-1:0]     widx;
    logic [31:0]       w  [16];
    logic [31:0]       hv [8];
    logic [31:0]       wk [8];

    logic [LEN_W-1:0]  nblk_calc;
    logic [JW-1:0]     tot_words;
    logic [63:0]       len_bits;
    logic [31:0]       w_in;
    logic [31:0]       w_next;
    logic [5:0]        rnd;
    logic [2:0]        wr_i;
    logic [31:0]       t1;
    logic [31:0]       t2;

    assign nblk_calc = LEN_W'((32'(msg_len) + 32'd2) >> 4) + LEN_W'(1);
    assign tot_words = {nblk, 4'b0000};
    assign len_bits  = 64'(len_q) << 5;
    assign rnd       = ~cnt[5:0];
    assign wr_i      = ~cnt[2:0];

    // Words at or past L never look at the read data, so stale memory beyond the message is harmless.
    always_comb begin
        if (widx < JW'(len_q))
            w_in = mem_read_data;
        else if (widx == JW'(len_q))
            w_in = 32'h80000000;
        else if (widx == tot_words - JW'(2))
            w_in = len_bits[63:32];
        else if (widx == tot_words - JW'(1))
            w_in = len_bits[31:0];
        else
            w_in = 32'h0;
    end

    always_comb begin
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
           + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K_TAB[rnd] + w[0];
        t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
           + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_addr  <= '0;
            out_addr <= '0;
            len_q    <= '0;
            nblk     <= '0;
            blk      <= '0;
            widx     <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= IV_P[255-32*i -: 32];
                wk[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    blk <= '0;
                    for (int i = 0; i < 8; i++) hv[i] <= IV_P[255-32*i -: 32];
                    if (start) begin
                        rd_addr  <= message_addr;
                        out_addr <= output_addr;
                        len_q    <= msg_len;
                        nblk     <= nblk_calc;
                        widx     <= '0;
                        cnt      <= 7'd16;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt != 7'd0) rd_addr <= rd_addr + ADDR_W'(1);
                    // Capture lags the address by one cycle to match the memory read latency.
                    if (cnt != 7'd16) begin
                        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                        w[15] <= w_in;
                        widx  <= widx + JW'(1);
                    end
                    if (cnt == 7'd0) begin
                        for (int i = 0; i < 8; i++) wk[i] <= hv[i];
                        cnt   <= 7'd63;
                        state <= S_COMPUTE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                S_COMPUTE: begin
                    wk[0] <= t1 + t2;
                    wk[1] <= wk[0];
                    wk[2] <= wk[1];
                    wk[3] <= wk[2];
                    wk[4] <= wk[3] + t1;
                    wk[5] <= wk[4];
                    wk[6] <= wk[5];
                    wk[7] <= wk[6];
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_next;
                    if (cnt == 7'd0) state <= S_UPDATE;
                    else             cnt   <= cnt - 7'd1;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wk[i];
                    blk <= blk + LEN_W'(1);
                    if (blk + LEN_W'(1) < nblk) begin
                        cnt   <= 7'd16;
                        state <= S_LOAD;
                    end else begin
                        cnt   <= 7'd7;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (cnt == 7'd0) state <= S_DONE;
                    else             cnt   <= cnt - 7'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign mem_clk = clk;

    // Memory outputs decode straight from state so an asynchronous reset kills a write at once.
    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (state == S_LOAD && cnt != 7'd0)
            mem_addr = rd_addr;
        if (state == S_WRITE) begin
            mem_we         = 1'b1;
            mem_addr       = out_addr + {{(ADDR_W-3){1'b0}}, wr_i};
            mem_write_data = hv[wr_i];
        end
    end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Bench for sha256_multiblock: random and directed hash requests against a plain SHA-256 model,
// with expected memory writes and done times queued and compared by an independent monitor.
module tb_sha256_multiblock;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] message_addr = '0;
    logic [11:0] msg_len = '0;
    logic [15:0] output_addr = '0;
    logic        busy, done, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;

    sha256_multiblock #(.ADDR_W(16), .LEN_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .message_addr(message_addr),
        .msg_len(msg_len), .output_addr(output_addr), .busy(busy), .done(done),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];
    int  dq[$];

    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    localparam logic [31:0] KC [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Standard SHA-256 of the len words starting at ma (wrapping), padded as a byte-aligned message.
    function automatic logic [255:0] sha_ref(input logic [15:0] ma, input int len);
        logic [31:0] p[$];
        logic [31:0] w[64];
        logic [31:0] h[8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        logic [63:0] nbits;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int j = 0; j < len; j++) p.push_back(mem[ma + 16'(j)]);
        p.push_back(32'h80000000);
        while (p.size() % 16 != 14) p.push_back(32'h0);
        nbits = 64'(len) * 64'd32;
        p.push_back(nbits[63:32]);
        p.push_back(nbits[31:0]);
        for (int bk = 0; bk < p.size() / 16; bk++) begin
            for (int t = 0; t < 16; t++) w[t] = p[bk*16 + t];
            for (int t = 16; t < 64; t++)
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KC[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {16'h0, mem_addr, mem_write_data}, 64'hx);
                end else begin
                    wr_t ex;
                    ex = wq.pop_front();
                    chk("write_addr", 64'(mem_addr), 64'(ex.addr));
                    chk("write_data", 64'(mem_write_data), 64'(ex.data));
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'(cyc), 64'hx);
                else                chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            end
        end
    end

    task automatic push_job(input logic [15:0] oa, input logic [255:0] dig, input int done_cyc);
        for (int i = 0; i < 8; i++) begin
            wr_t ex;
            ex.addr = oa + 16'(i);
            ex.data = dig[255-32*i -: 32];
            wq.push_back(ex);
        end
        dq.push_back(done_cyc);
    endtask

    // done is visible in the cycle after edge E0+82B+8, i.e. seen at the edge E0+82B+9.
    task automatic issue(input logic [15:0] ma, input int len, input logic [15:0] oa,
                         input int hold, input bit use_empty, output logic [255:0] dig);
        int e0;
        int nb;
        dig = use_empty ? EMPTY_DIGEST : sha_ref(ma, len);
        nb  = (len + 2) / 16 + 1;
        @(negedge clk);
        start        = 1'b1;
        message_addr = ma;
        msg_len      = 12'(len);
        output_addr  = oa;
        e0 = cyc + 1;
        push_job(oa, dig, e0 + 82*nb + 8);
        @(negedge clk);
        chk("first_mem_addr", 64'(mem_addr), 64'(ma));
        chk("busy_after_start", 64'(busy), 64'd1);
        message_addr = 16'($urandom);
        msg_len      = 12'($urandom);
        output_addr  = 16'($urandom);
        for (int i = 1; i < hold; i++) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || wq.size() != 0 || dq.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dig;
        logic [31:0]  pw;
        logic [15:0]  ma, oa;
        int len, e0, nw, nd, nwe;

        for (int i = 0; i < 65536; i++) mem[i] <= $urandom;
        pw = 32'h01234567;
        for (int i = 0; i < 19; i++) begin
            mem[i] <= pw;
            pw = {pw[30:0], pw[31]};
        end
        mem[19] <= 32'h0;

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_write_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(16'($urandom), 0, 16'h4000, 2, 1'b1, dig);
        wait_idle();

        issue(16'h0000, 20, 16'd1000, 1, 1'b0, dig);
        wait_idle();
        for (int i = 0; i < 8; i++)
            chk("mem_digest_l20", 64'(mem[16'd1000 + 16'(i)]), 64'(dig[255-32*i -: 32]));

        issue(16'h2000, 13, 16'h3000, 1, 1'b0, dig);
        wait_idle();
        issue(16'h2100, 14, 16'h3100, 1, 1'b0, dig);
        wait_idle();

        issue(16'hFFFC, 8, 16'hFFFE, 1, 1'b0, dig);
        wait_idle();

        for (int r = 0; r < 6; r++) begin
            ma  = 16'($urandom);
            len = (r == 5) ? 100 : int'($urandom_range(0, 40));
            issue(ma, len, ma ^ 16'h8000, 1, 1'b0, dig);
            wait_idle();
        end

        issue(16'($urandom), 0, 16'h5000, 1, 1'b1, dig);
        nw = 0;
        for (int i = 0; i < 200 && nw < 4; i++) begin
            @(posedge clk);
            #1;
            if (mem_we) nw++;
        end
        chk("abort_reached_4th_write", 64'(nw), 64'd4);
        reset = 1'b1;
        #1;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_writes_left", 64'(wq.size()), 64'd5);
        wq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        nwe = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (mem_we) nwe++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_no_writes", 64'(nwe), 64'd0);
        issue(16'($urandom), 0, 16'h5100, 1, 1'b1, dig);
        wait_idle();

        // start held high: a new L=0 hash is accepted every 92 cycles.
        oa = 16'h6000;
        @(negedge clk);
        start        = 1'b1;
        message_addr = 16'($urandom);
        msg_len      = 12'd0;
        output_addr  = oa;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) push_job(oa, EMPTY_DIGEST, e0 + 92*k + 90);
        for (int i = 0; i < 400 && cyc < e0 + 184; i++) @(negedge clk);
        chk("b2b_third_start_reached", 64'(cyc), 64'(e0 + 184));
        start = 1'b0;
        wait_idle();
        chk("b2b_all_consumed", 64'(wq.size() + dq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
